// File: rtl/main_fsm_if.sv
// main_fsm_if -- control bundle between the RV32I multi-cycle control FSM and
// the datapath / shared memory.
//
//   master : the control FSM. Consumes opcode and mem_ready and drives every
//            strobe, select and debug output.
//   slave  : datapath and memory side (the mirror image of master).
//
// Signals
//   opcode        7  instr[6:0] from the instruction register
//   mem_ready     1  memory completes the current access this cycle
//   mem_req       1  memory access requested
//   PCUpdate      1  PC load enable
//   Branch        1  conditional PC load (qualified by the datapath compare)
//   IRWrite       1  instruction register / OldPC load
//   RegWrite      1  register file write
//   MemWrite      1  memory write
//   AdrSrc        1  memory address select (0 PC, 1 Result)
//   ResultSrc     2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA       2  00 PC, 01 OldPC, 10 A
//   ALUSrcB       2  00 B, 01 ImmExt, 10 constant 4
//   ALUOp         2  00 add, 01 sub/compare, 10 funct decode, 11 pass SrcB
//   instr_retired 1  one-cycle pulse on instruction completion
//   state_dbg     4  current state encoding
interface main_fsm_if;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       mem_req;
   logic       PCUpdate;
   logic       Branch;
   logic       IRWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       AdrSrc;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       instr_retired;
   logic [3:0] state_dbg;

   modport master (
      input  opcode, mem_ready,
      output mem_req, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_retired, state_dbg
   );

   modport slave (
      output opcode, mem_ready,
      input  mem_req, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_retired, state_dbg
   );
endinterface

// File: rtl/main_fsm.sv
// main_fsm -- multi-cycle control state machine for the RV32I core.
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback and drives every datapath select and write enable. Memory accesses
// use a request/ready handshake so a shared instruction/data memory can stall
// the machine in FETCH, MEMREAD and MEMWRITE.
//
// Ports
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset; forces FETCH and masks strobes
//   bus  main_fsm_if.master  opcode/mem_ready in, strobes/selects/debug out
//
// Build option
//   MAIN_FSM_ILLEGAL_TRAP_EN  defined: unknown opcode locks into ERROR until
//                             reset. Undefined: unknown opcode retires as NOP.
module main_fsm (
   input  logic       clk,
   input  logic       rst,
   main_fsm_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JALR     = 4'd10,
      S_JAL      = 4'd11,
      S_LUI      = 4'd12,
      S_ERROR    = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   state_t     state, next;
   logic       mem_req_c, pcupdate_c, branch_c, irwrite_c;
   logic       regwrite_c, memwrite_c, adrsrc_c;
   logic [1:0] resultsrc_c, alusrca_c, alusrcb_c, aluop_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= next;
   end

   always_comb begin
      next        = state;
      mem_req_c   = 1'b0;
      pcupdate_c  = 1'b0;
      branch_c    = 1'b0;
      irwrite_c   = 1'b0;
      regwrite_c  = 1'b0;
      memwrite_c  = 1'b0;
      adrsrc_c    = 1'b0;
      resultsrc_c = 2'b00;
      alusrca_c   = 2'b00;
      alusrcb_c   = 2'b00;
      aluop_c     = 2'b00;
      case (state)
         S_FETCH: begin
            // PC+4 is formed while the instruction is read; the IR and PC
            // only load in the cycle memory actually returns the word.
            mem_req_c   = 1'b1;
            alusrcb_c   = 2'b10;
            resultsrc_c = 2'b10;
            if (bus.mem_ready) begin
               irwrite_c  = 1'b1;
               pcupdate_c = 1'b1;
               next       = S_DECODE;
            end
         end
         S_DECODE: begin
            // OldPC+imm lands in ALUOut: the branch/JAL target and the
            // complete AUIPC result.
            alusrca_c = 2'b01;
            alusrcb_c = 2'b01;
            case (bus.opcode)
               OP_LOAD, OP_STORE: next = S_MEMADR;
               OP_RTYPE:          next = S_EXECUTER;
               OP_ITYPE:          next = S_EXECUTEI;
               OP_BEQ:            next = S_BEQ;
               OP_JAL:            next = S_JAL;
               OP_JALR:           next = S_JALR;
               OP_LUI:            next = S_LUI;
               OP_AUIPC:          next = S_ALUWB;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
               default:           next = S_ERROR;
`else
               default:           next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alusrca_c = 2'b10;
            alusrcb_c = 2'b01;
            next      = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req_c = 1'b1;
            adrsrc_c  = 1'b1;
            if (bus.mem_ready) next = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc_c = 2'b01;
            regwrite_c  = 1'b1;
            next        = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_c  = 1'b1;
            adrsrc_c   = 1'b1;
            memwrite_c = 1'b1;
            if (bus.mem_ready) next = S_FETCH;
         end
         S_EXECUTER: begin
            alusrca_c = 2'b10;
            aluop_c   = 2'b10;
            next      = S_ALUWB;
         end
         S_EXECUTEI: begin
            alusrca_c = 2'b10;
            alusrcb_c = 2'b01;
            aluop_c   = 2'b10;
            next      = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            next       = S_FETCH;
         end
         S_BEQ: begin
            alusrca_c = 2'b10;
            aluop_c   = 2'b01;
            branch_c  = 1'b1;
            next      = S_FETCH;
         end
         S_JALR: begin
            alusrca_c = 2'b10;
            alusrcb_c = 2'b01;
            next      = S_JAL;
         end
         S_JAL: begin
            // PC loads the target held in ALUOut while the ALU forms the
            // link value OldPC+4 for ALUWB.
            alusrca_c  = 2'b01;
            alusrcb_c  = 2'b10;
            pcupdate_c = 1'b1;
            next       = S_ALUWB;
         end
         S_LUI: begin
            alusrcb_c = 2'b01;
            aluop_c   = 2'b11;
            next      = S_ALUWB;
         end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
         S_ERROR: next = S_ERROR;
`endif
         default: next = S_FETCH;
      endcase
   end

   // Strobes are masked by rst directly so none fires in the cycle reset
   // rises, before the asynchronous state change propagates.
   assign bus.mem_req       = mem_req_c  & ~rst;
   assign bus.PCUpdate      = pcupdate_c & ~rst;
   assign bus.Branch        = branch_c   & ~rst;
   assign bus.IRWrite       = irwrite_c  & ~rst;
   assign bus.RegWrite      = regwrite_c & ~rst;
   assign bus.MemWrite      = memwrite_c & ~rst;
   assign bus.AdrSrc        = adrsrc_c;
   assign bus.ResultSrc     = resultsrc_c;
   assign bus.ALUSrcA       = alusrca_c;
   assign bus.ALUSrcB       = alusrcb_c;
   assign bus.ALUOp         = aluop_c;
   assign bus.instr_retired = (next == S_FETCH) && (state != S_FETCH) && !rst;
   assign bus.state_dbg     = state;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm -- directed bench for main_fsm. Each instruction is expanded
// into its per-cycle list of expected control words from the instruction-class
// step sequences; a compare process checks every cycle against that list, and
// literal cycle/strobe counts pin the expansion itself.
module tb_main_fsm;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef struct packed {
      logic       mem_req;
      logic       pcupdate;
      logic       branch;
      logic       irwrite;
      logic       regwrite;
      logic       memwrite;
      logic       adrsrc;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       retired;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   main_fsm_if bus ();
   main_fsm dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   exp_t  expq[$];
   string nameq[$];
   int    total  = 0;
   int    passed = 0;
   int    cyc_n  = 0;
   int    ret_cnt = 0, regw_cnt = 0, memw_cnt = 0, last_ret = 0;

   function automatic exp_t mk(input logic mq, pcu, br, irw, rw, mw, adr,
                               input logic [1:0] rs, a, b, op,
                               input logic ret);
      exp_t e;
      e = '{mq, pcu, br, irw, rw, mw, adr, rs, a, b, op, ret};
      return e;
   endfunction

   // Control words of each step, straight from the step descriptions.
   function automatic exp_t e_reset();   return mk(0,0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0); endfunction
   function automatic exp_t e_fetch(input logic r);
                                         return mk(1,r,0,r,0,0,0,2'b10,2'b00,2'b10,2'b00,0); endfunction
   function automatic exp_t e_decode(input logic ret);
                                         return mk(0,0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,ret); endfunction
   function automatic exp_t e_memadr();  return mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0); endfunction
   function automatic exp_t e_memread(); return mk(1,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0); endfunction
   function automatic exp_t e_memwb();   return mk(0,0,0,0,1,0,0,2'b01,2'b00,2'b00,2'b00,1); endfunction
   function automatic exp_t e_memwrite(input logic r);
                                         return mk(1,0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,r); endfunction
   function automatic exp_t e_exer();    return mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0); endfunction
   function automatic exp_t e_exei();    return mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0); endfunction
   function automatic exp_t e_aluwb();   return mk(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,1); endfunction
   function automatic exp_t e_beq();     return mk(0,0,1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,1); endfunction
   function automatic exp_t e_jalr();    return mk(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0); endfunction
   function automatic exp_t e_jal();     return mk(0,1,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0); endfunction
   function automatic exp_t e_lui();     return mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b11,0); endfunction
   function automatic exp_t e_error();   return mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0); endfunction

   // Compare process: one expected word per driven cycle, checked mid-cycle.
   always @(negedge clk) begin
      exp_t  e, a;
      string nm;
      if (expq.size() > 0) begin
         e  = expq.pop_front();
         nm = nameq.pop_front();
         a  = '{bus.mem_req, bus.PCUpdate, bus.Branch, bus.IRWrite, bus.RegWrite,
                bus.MemWrite, bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUOp, bus.instr_retired};
         total++;
         if (a === e) passed++;
         else $display("FAIL %s t=%0t got=%b want=%b (mreq,pcu,br,irw,rw,mw,adr,rs,a,b,op,ret)",
                       nm, $time, a, e);
      end
   end

   // Activity counters for the literal checks.
   always @(negedge clk) begin
      cyc_n++;
      if (bus.instr_retired === 1'b1) begin ret_cnt++; last_ret = cyc_n; end
      if (bus.RegWrite === 1'b1) regw_cnt++;
      if (bus.MemWrite === 1'b1) memw_cnt++;
   end

   task automatic chk(input string nm, input int got, input int want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s got=%0d want=%0d", nm, got, want);
   endtask

   // Called at posedge+1: drive this cycle's inputs, queue its expectation.
   task automatic cyc(input logic rdy, input exp_t e, input string nm);
      bus.mem_ready = rdy;
      expq.push_back(e);
      nameq.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   int start_c, ret0, regw0, memw0;

   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input string nm);
      start_c = cyc_n + 1;
      ret0    = ret_cnt;
      regw0   = regw_cnt;
      memw0   = memw_cnt;
      bus.opcode = op;
      for (int i = 0; i < fw; i++) cyc(1'b0, e_fetch(1'b0), {nm, "_fetchwait"});
      cyc(1'b1, e_fetch(1'b1), {nm, "_fetch"});
      case (op)
         OP_LOAD: begin
            cyc(1'b0, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b0, e_memadr(), {nm, "_memadr"});
            for (int i = 0; i < mw; i++) cyc(1'b0, e_memread(), {nm, "_memread_wait"});
            cyc(1'b1, e_memread(), {nm, "_memread"});
            cyc(1'b1, e_memwb(), {nm, "_memwb"});
         end
         OP_STORE: begin
            cyc(1'b1, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b1, e_memadr(), {nm, "_memadr"});
            for (int i = 0; i < mw; i++) cyc(1'b0, e_memwrite(1'b0), {nm, "_memwrite_wait"});
            cyc(1'b1, e_memwrite(1'b1), {nm, "_memwrite"});
         end
         OP_RTYPE: begin
            cyc(1'b1, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b0, e_exer(), {nm, "_exer"});
            cyc(1'b1, e_aluwb(), {nm, "_aluwb"});
         end
         OP_ITYPE: begin
            cyc(1'b0, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b1, e_exei(), {nm, "_exei"});
            cyc(1'b0, e_aluwb(), {nm, "_aluwb"});
         end
         OP_BEQ: begin
            cyc(1'b1, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b1, e_beq(), {nm, "_beq"});
         end
         OP_JAL: begin
            cyc(1'b1, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b1, e_jal(), {nm, "_jal"});
            cyc(1'b1, e_aluwb(), {nm, "_aluwb"});
         end
         OP_JALR: begin
            cyc(1'b1, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b0, e_jalr(), {nm, "_jalr"});
            cyc(1'b1, e_jal(), {nm, "_jal"});
            cyc(1'b1, e_aluwb(), {nm, "_aluwb"});
         end
         OP_LUI: begin
            cyc(1'b1, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b1, e_lui(), {nm, "_lui"});
            cyc(1'b1, e_aluwb(), {nm, "_aluwb"});
         end
         OP_AUIPC: begin
            cyc(1'b1, e_decode(1'b0), {nm, "_decode"});
            cyc(1'b1, e_aluwb(), {nm, "_aluwb"});
         end
         default: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            cyc(1'b1, e_decode(1'b0), {nm, "_decode"});
            for (int i = 0; i < 4; i++) cyc(i[0], e_error(), {nm, "_error"});
            rst = 1'b1;
            cyc(1'b1, e_reset(), {nm, "_reset"});
            rst = 1'b0;
`else
            cyc(1'b1, e_decode(1'b1), {nm, "_decode_nop"});
`endif
         end
      endcase
   endtask

   initial begin
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      bus.opcode = OP_RTYPE;
      @(posedge clk);
      #1;
      cyc(1'b1, e_reset(), "reset0");
      cyc(1'b1, e_reset(), "reset1");
      rst = 1'b0;

      // R-type straight out of reset: FETCH with ready=1, then DECODE.
      run_instr(OP_RTYPE, 0, 0, "rtype");
      chk("rtype_cycles", last_ret - start_c + 1, 4);

      // Load with two wait states in MEMREAD: 7 cycles, one RegWrite.
      run_instr(OP_LOAD, 0, 2, "load_w2");
      chk("load_w2_cycles", last_ret - start_c + 1, 7);
      chk("load_w2_regwrite", regw_cnt - regw0, 1);
      chk("load_w2_retired", ret_cnt - ret0, 1);

      // Store with one wait state: MemWrite high two cycles, no RegWrite.
      run_instr(OP_STORE, 0, 1, "store_w1");
      chk("store_w1_memwrite", memw_cnt - memw0, 2);
      chk("store_w1_regwrite", regw_cnt - regw0, 0);
      chk("store_w1_cycles", last_ret - start_c + 1, 5);

      run_instr(OP_JALR, 0, 0, "jalr");
      chk("jalr_cycles", last_ret - start_c + 1, 5);

      run_instr(OP_ITYPE, 2, 0, "itype_fw2");
      chk("itype_fw2_cycles", last_ret - start_c + 1, 6);
      run_instr(OP_BEQ, 0, 0, "beq");
      chk("beq_cycles", last_ret - start_c + 1, 3);
      run_instr(OP_JAL, 0, 0, "jal");
      run_instr(OP_LUI, 0, 0, "lui");
      run_instr(OP_AUIPC, 0, 0, "auipc");
      chk("auipc_cycles", last_ret - start_c + 1, 3);
      run_instr(OP_LOAD, 1, 0, "load_fw1");

      // Unknown opcode.
      run_instr(7'b0000000, 0, 0, "illegal");
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      chk("illegal_retired", ret_cnt - ret0, 0);
`else
      chk("illegal_retired", ret_cnt - ret0, 1);
`endif

      // Reset raised mid-cycle during MEMWRITE.
      bus.opcode = OP_STORE;
      cyc(1'b1, e_fetch(1'b1), "rstmw_fetch");
      cyc(1'b1, e_decode(1'b0), "rstmw_decode");
      cyc(1'b1, e_memadr(), "rstmw_memadr");
      bus.mem_ready = 1'b0;
      expq.push_back(e_memwrite(1'b0));
      nameq.push_back("rstmw_memwrite");
      @(negedge clk);
      #2;
      rst = 1'b1;
      memw0 = memw_cnt;
      #1;
      chk("rstmw_memwrite_async", int'(bus.MemWrite), 0);
      chk("rstmw_memreq_async", int'(bus.mem_req), 0);
      @(posedge clk);
      #1;
      cyc(1'b1, e_reset(), "rstmw_reset");
      chk("rstmw_no_write_after_rst", memw_cnt - memw0, 0);
      rst = 1'b0;
      run_instr(OP_RTYPE, 0, 0, "post_rst_rtype");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multi-cycle control state machine for the RV32I processor. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and write-enable. It consumes the 7-bit opcode from the instruction register, alongside the instruction decoder that produces `immSrc`. Memory accesses use a single-request/ready handshake so that shared instruction/data memory can stall the machine.

## Interface
- No parameters.
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — asynchronous, active-high reset.
- `opcode` in 7 — `instr[6:0]` from the instruction register.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `mem_req` out 1 — memory access requested.
- `PCUpdate` out 1 — PC load enable.
- `Branch` out 1 — conditional PC load; the datapath qualifies it with the comparison.
- `IRWrite` out 1 — instruction register / OldPC load.
- `RegWrite` out 1 — register file write.
- `MemWrite` out 1 — memory write.
- `AdrSrc` out 1 — memory address select: 0 = PC, 1 = Result.
- `ResultSrc` out 2 — 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2 — 00 = PC, 01 = OldPC, 10 = A (rs1 register).
- `ALUSrcB` out 2 — 00 = B (rs2 register), 01 = ImmExt, 10 = constant 4.
- `ALUOp` out 2 — 00 = add, 01 = subtract/compare, 10 = decode funct3/funct7, 11 = pass SrcB.
- `instr_retired` out 1 — one-cycle pulse on instruction completion.
- `state_dbg` out 4 — current state encoding.

## Operation
- Moore machine. Outputs decode from the state register only, except the `mem_ready` gating listed below. Any select not listed for a state is 00/0.
- FETCH:
  - `mem_req`, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - `IRWrite` and `PCUpdate` assert only when `mem_ready`=1.
  - Goes to DECODE on `mem_ready`; otherwise stays.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00. This precomputes OldPC+imm into ALUOut.
  - Transitions by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → ALUWB (AUIPC result is already in ALUOut)
    - any other opcode → illegal handling (see Configuration).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for a load opcode, MEMWRITE for a store opcode.
- MEMREAD: `mem_req`, AdrSrc=1, ResultSrc=00. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: `mem_req`, AdrSrc=1, ResultSrc=00. `MemWrite` is held high until `mem_ready`, then goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (rs1+imm into ALUOut). Goes to JAL.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - The PC takes the target from ALUOut while the ALU computes OldPC+4.
  - Goes to ALUWB.
- LUI: ALUSrcB=01, ALUOp=11. Goes to ALUWB.
- `instr_retired` pulses in every cycle whose next state is FETCH and whose current state is not FETCH.

## Timing
- Reset:
  - State becomes FETCH immediately (asynchronous).
  - While `rst`=1, `mem_req`, `PCUpdate`, `Branch`, `IRWrite`, `RegWrite`, `MemWrite` and `instr_retired` are forced to 0.
  - The selects show the FETCH values; `state_dbg` shows the FETCH code.
- Reset asserted mid-instruction abandons the instruction; no write strobe fires after `rst` rises.
- Cycles per instruction with zero wait states:
  - Load: 5.
  - Store, R-type, I-type ALU, JAL, LUI: 4.
  - JALR: 5.
  - AUIPC, BEQ: 3.
- Each low `mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_req` holds stable until the cycle `mem_ready` is sampled high. `mem_ready` outside those states is ignored.
- `opcode` is sampled only in DECODE and MEMADR. The instruction register must not change between FETCH and retirement.

## Configuration
- `MAIN_FSM_ILLEGAL_TRAP_EN`:
  - Defined: an unknown opcode in DECODE enters a terminal ERROR state. In ERROR all strobes are 0 and `instr_retired` is 0. Only `rst` exits ERROR.
  - Undefined: an unknown opcode goes DECODE → FETCH and is treated as a NOP, with `instr_retired` pulsing on that transition.

## Test plan
- Reset with `mem_ready`=1, release → FETCH has IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10; DECODE follows on the next cycle.
- Load (0000011), `mem_ready` low for 2 cycles in MEMREAD → states run FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB; RegWrite=1 with ResultSrc=01 for exactly one cycle; `instr_retired` pulses once; total 7 cycles.
- Store (0100011) with `mem_ready`=0 for 1 cycle → MemWrite=1 for 2 consecutive cycles with AdrSrc=1; RegWrite never asserts.
- JALR (1100111) → sequence DECODE, JALR, JAL, ALUWB; PCUpdate in JAL with ResultSrc=00; RegWrite in ALUWB.
- Opcode 0000000:
  - Macro undefined → returns to FETCH after DECODE with one `instr_retired` pulse.
  - Macro defined → sticks in ERROR with all strobes 0 until `rst`.
- `rst` asserted during MEMWRITE → MemWrite drops in the same cycle (asynchronous); FETCH state after release.
